// File: rtl/transcribe_pkg.sv
// Shared types and tempo constants for the music-transcription pipeline.
package transcribe_pkg;

    localparam int NOTE_WIDTH_DEFAULT = 6;

    typedef logic [NOTE_WIDTH_DEFAULT-1:0] note_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_FULL   = 2'd2
    } rec_state_t;

    localparam note_t REST_NOTE_DEFAULT = '0;

    // Audio-domain master clock; an eighth note lasts half a second.
    localparam int CLK_M_HZ         = 69632000;
    localparam int EIGHTHS_PER_SEC  = 2;
    localparam int TICKS_PER_EIGHTH = CLK_M_HZ / EIGHTHS_PER_SEC;

endpackage

// File: rtl/slot_timer.sv
// Free-running slot counter with synchronous clear and a terminal-count flag.
// Kept separate so the same tempo logic can drive playback.
module slot_timer #(
    parameter int TICKS = 5
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear_in,
    input  logic run_in,
    output logic tc_out
);

    localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Terminal count is only meaningful while running and not being cleared.
    assign tc_out = run_in && !clear_in && (count_q == LAST);

    // Next count: clear wins, otherwise wrap at LAST.
    always_comb begin
        count_d = count_q;
        if (clear_in) begin
            count_d = '0;
        end else if (run_in) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/note_recorder.sv
// Quantises the detected note stream into fixed-length slots and keeps one
// note index per slot, with rest detection, optional ring mode and FULL stop.
module note_recorder
    import transcribe_pkg::*;
#(
    parameter int NUM_SLOTS      = 160,
    parameter int NOTE_WIDTH     = NOTE_WIDTH_DEFAULT,
    parameter int TICKS_PER_SLOT = TICKS_PER_EIGHTH,
    parameter int REST_NOTE      = int'(REST_NOTE_DEFAULT),
    localparam int IDX_WIDTH     = $clog2(NUM_SLOTS + 1)
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 enable_in,
    input  logic                                 loop_in,
    input  logic [NOTE_WIDTH-1:0]                note_in,
    input  logic                                 note_valid_in,
    output logic [NUM_SLOTS-1:0][NOTE_WIDTH-1:0] notes_out,
    output logic [IDX_WIDTH-1:0]                 write_idx_out,
    output logic                                 recording_out,
    output logic                                 full_out,
    output logic                                 slot_tick_out
);

    localparam logic [NOTE_WIDTH-1:0] REST_CODE = NOTE_WIDTH'(REST_NOTE);
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_SLOTS - 1);
    localparam logic [IDX_WIDTH-1:0]  FULL_IDX  = IDX_WIDTH'(NUM_SLOTS);

    rec_state_t              state_q, state_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic [NOTE_WIDTH-1:0]   latch_q, latch_d;
    logic                    seen_q, seen_d;
    logic                    tick_q, tick_d;
    logic                    recording_q, recording_d;
    logic                    full_q, full_d;

    logic                    slot_tc;
    logic                    timer_clear;
    logic                    clear_buf;
    logic                    commit_en;
    logic [NOTE_WIDTH-1:0]   wr_data;

    // The counter only runs while recording is requested; any other cycle parks it at 0.
    assign timer_clear = (state_q != ST_RECORD) || !enable_in;

    slot_timer #(
        .TICKS (TICKS_PER_SLOT)
    ) u_slot_timer (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear_in (timer_clear),
        .run_in   (state_q == ST_RECORD),
        .tc_out   (slot_tc)
    );

    // A strobe on the commit cycle itself belongs to the slot being committed.
    assign wr_data = note_valid_in ? note_in : (seen_q ? latch_q : REST_CODE);

    // Next-state, index, note latch and status decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        latch_d   = latch_q;
        seen_d    = seen_q;
        tick_d    = 1'b0;
        clear_buf = 1'b0;
        commit_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_in) begin
                    state_d   = ST_RECORD;
                    clear_buf = 1'b1;
                    idx_d     = '0;
                    seen_d    = 1'b0;
                    latch_d   = REST_CODE;
                end
            end
            ST_RECORD: begin
                if (!enable_in) begin
                    // Stopping beats a same-cycle commit; the slot is dropped.
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    if (note_valid_in) begin
                        latch_d = note_in;
                        seen_d  = 1'b1;
                    end
                    if (slot_tc) begin
                        commit_en = 1'b1;
                        tick_d    = 1'b1;
                        seen_d    = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            if (loop_in) begin
                                idx_d = '0;
                            end else begin
                                idx_d   = FULL_IDX;
                                state_d = ST_FULL;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            ST_FULL: begin
                if (!enable_in) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        recording_d = (state_d == ST_RECORD);
        full_d      = (state_d == ST_FULL);
    end

    // Control and status registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            latch_q     <= REST_CODE;
            seen_q      <= 1'b0;
            tick_q      <= 1'b0;
            recording_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            latch_q     <= latch_d;
            seen_q      <= seen_d;
            tick_q      <= tick_d;
            recording_q <= recording_d;
            full_q      <= full_d;
        end
    end

    // One register per slot, written only when the index points at it.
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        logic [NOTE_WIDTH-1:0] slot_q;

        // Slot storage: reset/clear to rest, else capture on its commit.
        always_ff @(posedge clk_in) begin
            if (!rst_in) begin
                slot_q <= REST_CODE;
            end else if (clear_buf) begin
                slot_q <= REST_CODE;
            end else if (commit_en && (idx_q == IDX_WIDTH'(gi))) begin
                slot_q <= wr_data;
            end
        end

        assign notes_out[gi] = slot_q;
    end

    assign write_idx_out = idx_q;
    assign recording_out = recording_q;
    assign full_out      = full_q;
    assign slot_tick_out = tick_q;

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with 4 slots of 5 ticks each.
module tb_note_recorder;

    localparam int NS  = 4;
    localparam int NW  = 6;
    localparam int TPS = 5;
    localparam int IW  = $clog2(NS + 1);

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic                   enable_in;
    logic                   loop_in;
    logic [NW-1:0]          note_in;
    logic                   note_valid_in;
    logic [NS-1:0][NW-1:0]  notes_out;
    logic [IW-1:0]          write_idx_out;
    logic                   recording_out;
    logic                   full_out;
    logic                   slot_tick_out;

    int errors = 0;
    int checks = 0;

    note_recorder #(
        .NUM_SLOTS      (NS),
        .NOTE_WIDTH     (NW),
        .TICKS_PER_SLOT (TPS),
        .REST_NOTE      (0)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .enable_in     (enable_in),
        .loop_in       (loop_in),
        .note_in       (note_in),
        .note_valid_in (note_valid_in),
        .notes_out     (notes_out),
        .write_idx_out (write_idx_out),
        .recording_out (recording_out),
        .full_out      (full_out),
        .slot_tick_out (slot_tick_out)
    );

    always #5 clk_in = ~clk_in;

    // One clock with an optional strobe; outputs are stable on return (#1 after edge).
    task automatic cyc(input logic v, input logic [NW-1:0] n);
        note_valid_in = v;
        note_in       = n;
        @(posedge clk_in);
        #1;
        note_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; enable_in = 1'b1; loop_in = 1'b0;
        repeat (3) cyc(1'b0, '0);
        checks++; if (recording_out !== 1'b0) begin errors++; $display("FAIL reset_rec: got %b expected 0", recording_out); end
        checks++; if (full_out !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full_out); end
        checks++; if (slot_tick_out !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", slot_tick_out); end
        checks++; if (write_idx_out !== '0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", write_idx_out); end
        for (int i = 0; i < NS; i++) begin
            checks++; if (notes_out[i] !== '0) begin errors++; $display("FAIL reset_slot%0d: got %0d expected 0", i, notes_out[i]); end
        end
        rst_in = 1'b1; enable_in = 1'b0;
        cyc(1'b0, '0);
        checks++; if (recording_out !== 1'b0) begin errors++; $display("FAIL reset_stay_idle: got %b expected 0", recording_out); end
        $display("test_reset: idx=%0d rec=%b full=%b", write_idx_out, recording_out, full_out);
    endtask

    task automatic test_basic();
        enable_in = 1'b1;
        cyc(1'b0, '0);
        checks++; if (recording_out !== 1'b1) begin errors++; $display("FAIL basic_rec: got %b expected 1", recording_out); end
        for (int c = 0; c < TPS; c++) begin
            cyc(c == 2 || c == 4, (c == 2) ? 6'd12 : 6'd17);
            if (c == 3) begin
                checks++; if (slot_tick_out !== 1'b0) begin errors++; $display("FAIL basic_early_tick: got %b expected 0", slot_tick_out); end
            end
        end
        checks++; if (slot_tick_out !== 1'b1) begin errors++; $display("FAIL basic_tick0: got %b expected 1", slot_tick_out); end
        checks++; if (notes_out[0] !== 6'd17) begin errors++; $display("FAIL basic_slot0: got %0d expected 17", notes_out[0]); end
        checks++; if (write_idx_out !== 3'd1) begin errors++; $display("FAIL basic_idx1: got %0d expected 1", write_idx_out); end
        $display("test_basic: slot0=%0d idx=%0d", notes_out[0], write_idx_out);
        for (int c = 0; c < TPS; c++) begin
            cyc(1'b0, '0);
            if (c == 0) begin
                checks++; if (slot_tick_out !== 1'b0) begin errors++; $display("FAIL basic_tick_pulse: got %b expected 0", slot_tick_out); end
            end
        end
        checks++; if (slot_tick_out !== 1'b1) begin errors++; $display("FAIL basic_tick1: got %b expected 1", slot_tick_out); end
        checks++; if (notes_out[1] !== 6'd0) begin errors++; $display("FAIL basic_rest: got %0d expected 0", notes_out[1]); end
        checks++; if (write_idx_out !== 3'd2) begin errors++; $display("FAIL basic_idx2: got %0d expected 2", write_idx_out); end
        $display("test_basic: slot1=%0d idx=%0d", notes_out[1], write_idx_out);
        enable_in = 1'b0;
        cyc(1'b0, '0);
        checks++; if (recording_out !== 1'b0) begin errors++; $display("FAIL basic_stop_rec: got %b expected 0", recording_out); end
        checks++; if (write_idx_out !== 3'd0) begin errors++; $display("FAIL basic_stop_idx: got %0d expected 0", write_idx_out); end
        checks++; if (notes_out[0] !== 6'd17) begin errors++; $display("FAIL basic_kept: got %0d expected 17", notes_out[0]); end
    endtask

    task automatic test_fill_no_loop();
        loop_in = 1'b0; enable_in = 1'b1;
        cyc(1'b0, '0);
        checks++; if (notes_out[0] !== 6'd0) begin errors++; $display("FAIL fill_cleared: got %0d expected 0", notes_out[0]); end
        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < TPS; c++) cyc(c == 1, 6'd9);
            if (s < NS - 1) begin
                checks++; if (full_out !== 1'b0) begin errors++; $display("FAIL fill_early_full s%0d: got %b expected 0", s, full_out); end
            end
        end
        checks++; if (full_out !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full_out); end
        checks++; if (recording_out !== 1'b0) begin errors++; $display("FAIL fill_rec: got %b expected 0", recording_out); end
        checks++; if (write_idx_out !== 3'd4) begin errors++; $display("FAIL fill_idx: got %0d expected 4", write_idx_out); end
        checks++; if (slot_tick_out !== 1'b1) begin errors++; $display("FAIL fill_tick: got %b expected 1", slot_tick_out); end
        for (int i = 0; i < NS; i++) begin
            checks++; if (notes_out[i] !== 6'd9) begin errors++; $display("FAIL fill_slot%0d: got %0d expected 9", i, notes_out[i]); end
        end
        $display("test_fill: full=%b idx=%0d", full_out, write_idx_out);
        for (int k = 0; k < 10; k++) cyc(1'b1, 6'd3);
        for (int i = 0; i < NS; i++) begin
            checks++; if (notes_out[i] !== 6'd9) begin errors++; $display("FAIL fill_frozen%0d: got %0d expected 9", i, notes_out[i]); end
        end
        checks++; if (slot_tick_out !== 1'b0) begin errors++; $display("FAIL fill_no_tick: got %b expected 0", slot_tick_out); end
        checks++; if (full_out !== 1'b1) begin errors++; $display("FAIL fill_hold_full: got %b expected 1", full_out); end
        enable_in = 1'b0;
        cyc(1'b0, '0);
        checks++; if (full_out !== 1'b0) begin errors++; $display("FAIL fill_exit_full: got %b expected 0", full_out); end
        checks++; if (write_idx_out !== 3'd0) begin errors++; $display("FAIL fill_exit_idx: got %0d expected 0", write_idx_out); end
        checks++; if (notes_out[3] !== 6'd9) begin errors++; $display("FAIL fill_exit_kept: got %0d expected 9", notes_out[3]); end
    endtask

    task automatic test_loop();
        logic [NW-1:0] exp_notes [NS];
        logic          saw_full;
        exp_notes[0] = 6'd5; exp_notes[1] = 6'd2; exp_notes[2] = 6'd3; exp_notes[3] = 6'd4;
        saw_full = 1'b0;
        loop_in = 1'b1; enable_in = 1'b1;
        cyc(1'b0, '0);
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < TPS; c++) begin
                cyc(c == 0, NW'(s + 1));
                if (full_out) saw_full = 1'b1;
            end
        end
        for (int i = 0; i < NS; i++) begin
            checks++; if (notes_out[i] !== exp_notes[i]) begin errors++; $display("FAIL loop_slot%0d: got %0d expected %0d", i, notes_out[i], exp_notes[i]); end
        end
        checks++; if (write_idx_out !== 3'd1) begin errors++; $display("FAIL loop_idx: got %0d expected 1", write_idx_out); end
        checks++; if (saw_full !== 1'b0) begin errors++; $display("FAIL loop_full: got %b expected 0", saw_full); end
        checks++; if (recording_out !== 1'b1) begin errors++; $display("FAIL loop_rec: got %b expected 1", recording_out); end
        $display("test_loop: notes=%0d,%0d,%0d,%0d idx=%0d", notes_out[0], notes_out[1], notes_out[2], notes_out[3], write_idx_out);
        enable_in = 1'b0; loop_in = 1'b0;
        cyc(1'b0, '0);
    endtask

    task automatic test_edges();
        enable_in = 1'b1;
        cyc(1'b0, '0);
        checks++; if (notes_out[1] !== 6'd0) begin errors++; $display("FAIL edge_clear: got %0d expected 0", notes_out[1]); end
        for (int c = 0; c < TPS; c++) cyc(c == TPS - 1, 6'd30);
        checks++; if (notes_out[0] !== 6'd30) begin errors++; $display("FAIL edge_commit_strobe: got %0d expected 30", notes_out[0]); end
        $display("test_edges: slot0=%0d", notes_out[0]);
        for (int c = 0; c < TPS - 1; c++) cyc(c == 1, 6'd7);
        enable_in = 1'b0;
        cyc(1'b0, '0);
        checks++; if (recording_out !== 1'b0) begin errors++; $display("FAIL edge_drop_rec: got %b expected 0", recording_out); end
        checks++; if (slot_tick_out !== 1'b0) begin errors++; $display("FAIL edge_drop_tick: got %b expected 0", slot_tick_out); end
        checks++; if (notes_out[1] !== 6'd0) begin errors++; $display("FAIL edge_drop_slot1: got %0d expected 0", notes_out[1]); end
        checks++; if (write_idx_out !== 3'd0) begin errors++; $display("FAIL edge_drop_idx: got %0d expected 0", write_idx_out); end
        enable_in = 1'b1;
        cyc(1'b0, '0);
        checks++; if (notes_out[0] !== 6'd0) begin errors++; $display("FAIL edge_reenable_clear: got %0d expected 0", notes_out[0]); end
        checks++; if (recording_out !== 1'b1) begin errors++; $display("FAIL edge_reenable_rec: got %b expected 1", recording_out); end
        $display("test_edges: re-enable slot0=%0d rec=%b", notes_out[0], recording_out);
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < TPS; c++) cyc(c == 0, 6'd11);
        for (int c = 0; c < TPS; c++) cyc(c == 0, 6'd13);
        checks++; if (notes_out[1] !== 6'd13) begin errors++; $display("FAIL mid_pre_slot1: got %0d expected 13", notes_out[1]); end
        cyc(1'b1, 6'd20);
        cyc(1'b0, '0);
        rst_in = 1'b0;
        cyc(1'b0, '0);
        checks++; if (notes_out[0] !== 6'd0) begin errors++; $display("FAIL mid_slot0: got %0d expected 0", notes_out[0]); end
        checks++; if (notes_out[1] !== 6'd0) begin errors++; $display("FAIL mid_slot1: got %0d expected 0", notes_out[1]); end
        checks++; if (write_idx_out !== 3'd0) begin errors++; $display("FAIL mid_idx: got %0d expected 0", write_idx_out); end
        checks++; if (recording_out !== 1'b0) begin errors++; $display("FAIL mid_rec: got %b expected 0", recording_out); end
        rst_in = 1'b1;
        cyc(1'b0, '0);
        checks++; if (recording_out !== 1'b1) begin errors++; $display("FAIL mid_restart: got %b expected 1", recording_out); end
        for (int c = 0; c < TPS - 1; c++) cyc(c == 2, 6'd21);
        checks++; if (slot_tick_out !== 1'b0) begin errors++; $display("FAIL mid_early_tick: got %b expected 0", slot_tick_out); end
        cyc(1'b0, '0);
        checks++; if (slot_tick_out !== 1'b1) begin errors++; $display("FAIL mid_tick: got %b expected 1", slot_tick_out); end
        checks++; if (notes_out[0] !== 6'd21) begin errors++; $display("FAIL mid_slot0_new: got %0d expected 21", notes_out[0]); end
        checks++; if (write_idx_out !== 3'd1) begin errors++; $display("FAIL mid_idx_new: got %0d expected 1", write_idx_out); end
        $display("test_reset_mid: slot0=%0d idx=%0d", notes_out[0], write_idx_out);
    endtask

    initial begin
        rst_in = 1'b0; enable_in = 1'b0; loop_in = 1'b0;
        note_in = '0; note_valid_in = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_fill_no_loop();
        test_loop();
        test_edges();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
